// File: rtl/pipeline_debug_unit.sv
// Debug controller in front of the MIPS pipeline: gates pipe_clk_en for run/step and streams a PC/reg/mem snapshot frame.
// Bytes are held on tx_data until tx_ready; PIPELINE_DEBUG_CYCLE_COUNT_EN adds an enabled-cycle counter word to the frame.
`timescale 1ns/1ps

module pipeline_debug_unit #(
   parameter int unsigned MEM_WORDS  = 32,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   input  logic [7:0]    cmd_data,
   input  logic [31:0]   instruction_if,
   input  logic [31:0]   pc_if,
   input  logic [1023:0] regs_flat,
   input  logic [31:0]   mem_rdata,
   output logic          pipe_clk_en,
   output logic          debug_mode,
   output logic [31:0]   debug_addr,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   input  logic          tx_ready,
   output logic          busy
);

   localparam logic [7:0] CMD_RUN  = 8'h63;
   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_DUMP = 8'h64;
   localparam logic [7:0] CMD_HALT = 8'h68;
   localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
   localparam int unsigned CNT_WORDS = 1;
`else
   localparam int unsigned CNT_WORDS = 0;
`endif
   localparam int unsigned REG_BASE = CNT_WORDS + 1;
   localparam int unsigned MEM_BASE = CNT_WORDS + 33;
   localparam int unsigned NW       = MEM_BASE + MEM_WORDS;
   localparam int          WW       = $clog2(NW);
   localparam logic [WW-1:0] LAST_IDX = WW'(NW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_LOAD,
      S_WAIT_MEM,
      S_SEND,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            pipe_clk_en_q, pipe_clk_en_d;
   logic            debug_mode_q, debug_mode_d;
   logic [31:0]     debug_addr_q, debug_addr_d;
   logic            tx_valid_q, tx_valid_d;
   logic [31:0]     shift_q, shift_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [WW-1:0]   word_idx_q, word_idx_d;
   logic            hdr_pend_q, hdr_pend_d;
   logic            busy_q, busy_d;

   logic [31:0]     word_sel;
   logic [31:0]     mem_addr;
   logic [4:0]      reg_idx;
   logic            is_mem;
   logic            stop_run;

`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
   logic [31:0]     cyc_cnt_q, cyc_cnt_d;

   // Counts every edge on which the pipeline actually advances.
   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      if (pipe_clk_en_q) begin
         cyc_cnt_d = cyc_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
      end
   end
`endif

   always_comb begin
      reg_idx  = 5'(word_idx_q - WW'(REG_BASE));
      mem_addr = 32'(word_idx_q) - MEM_BASE;
      is_mem   = (word_idx_q >= WW'(MEM_BASE));
      word_sel = pc_if;
      if (word_idx_q >= WW'(REG_BASE) && !is_mem) begin
         word_sel = regs_flat[{reg_idx, 5'b00000} +: 32];
      end
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
      if (word_idx_q == '0) begin
         word_sel = cyc_cnt_q;
      end
`endif
   end

   assign stop_run = (instruction_if == HALT_INSTR) || (cmd_valid && (cmd_data == CMD_HALT));

   always_comb begin
      state_d       = state_q;
      pipe_clk_en_d = pipe_clk_en_q;
      debug_mode_d  = debug_mode_q;
      debug_addr_d  = debug_addr_q;
      tx_valid_d    = tx_valid_q;
      shift_d       = shift_q;
      byte_cnt_d    = byte_cnt_q;
      word_idx_d    = word_idx_q;
      hdr_pend_d    = hdr_pend_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_data)
                  CMD_RUN: begin
                     state_d       = S_RUN;
                     pipe_clk_en_d = 1'b1;
                  end
                  CMD_STEP: begin
                     state_d       = S_STEP;
                     pipe_clk_en_d = 1'b1;
                  end
                  CMD_DUMP: begin
                     state_d    = S_LOAD;
                     hdr_pend_d = 1'b1;
                     word_idx_d = '0;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // The halting edge still advances the pipeline; the freeze starts right after it.
            if (stop_run) begin
               state_d       = S_LOAD;
               pipe_clk_en_d = 1'b0;
               hdr_pend_d    = 1'b1;
               word_idx_d    = '0;
            end
         end
         S_STEP: begin
            state_d       = S_LOAD;
            pipe_clk_en_d = 1'b0;
            hdr_pend_d    = 1'b1;
            word_idx_d    = '0;
         end
         S_LOAD: begin
            if (hdr_pend_q) begin
               // The header is a single byte: park it in the top lane and jump to the last byte slot.
               shift_d    = {HDR_BYTE, 24'h000000};
               byte_cnt_d = 2'd3;
               tx_valid_d = 1'b1;
               state_d    = S_SEND;
            end else if (is_mem) begin
               debug_mode_d = 1'b1;
               debug_addr_d = mem_addr;
               state_d      = S_WAIT_MEM;
            end else begin
               shift_d    = word_sel;
               byte_cnt_d = 2'd0;
               tx_valid_d = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_WAIT_MEM: begin
            shift_d    = mem_rdata;
            byte_cnt_d = 2'd0;
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (tx_ready) begin
               shift_d = {shift_q[23:0], 8'h00};
               if (byte_cnt_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  if (hdr_pend_q) begin
                     hdr_pend_d = 1'b0;
                     state_d    = S_LOAD;
                  end else if (word_idx_q == LAST_IDX) begin
                     state_d = S_DONE;
                  end else begin
                     word_idx_d = word_idx_q + 1'b1;
                     state_d    = S_LOAD;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         S_DONE: begin
            state_d      = S_IDLE;
            debug_mode_d = 1'b0;
            word_idx_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pipe_clk_en_q <= 1'b0;
         debug_mode_q  <= 1'b0;
         debug_addr_q  <= '0;
         tx_valid_q    <= 1'b0;
         shift_q       <= '0;
         byte_cnt_q    <= '0;
         word_idx_q    <= '0;
         hdr_pend_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pipe_clk_en_q <= pipe_clk_en_d;
         debug_mode_q  <= debug_mode_d;
         debug_addr_q  <= debug_addr_d;
         tx_valid_q    <= tx_valid_d;
         shift_q       <= shift_d;
         byte_cnt_q    <= byte_cnt_d;
         word_idx_q    <= word_idx_d;
         hdr_pend_q    <= hdr_pend_d;
         busy_q        <= busy_d;
      end
   end

   assign pipe_clk_en = pipe_clk_en_q;
   assign debug_mode  = debug_mode_q;
   assign debug_addr  = debug_addr_q;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = shift_q[31:24];
   assign busy        = busy_q;

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Bench for pipeline_debug_unit: random pipeline state and backpressure against a frame-building reference model.
`timescale 1ns/1ps

module tb_pipeline_debug_unit;

   localparam int          MW   = 32;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam int          RXN  = 8192;
`ifdef PIPELINE_DEBUG_CYCLE_COUNT_EN
   localparam int          CW   = 1;
`else
   localparam int          CW   = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic [7:0]    cmd_data;
   logic [31:0]   instruction_if = 32'h0;
   logic [31:0]   pc_if;
   logic [1023:0] regs_flat;
   logic [31:0]   mem_rdata;
   logic          pipe_clk_en;
   logic          debug_mode;
   logic [31:0]   debug_addr;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          busy;

   pipeline_debug_unit #(.MEM_WORDS(MW), .HALT_INSTR(HALT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_data       (cmd_data),
      .instruction_if (instruction_if),
      .pc_if          (pc_if),
      .regs_flat      (regs_flat),
      .mem_rdata      (mem_rdata),
      .pipe_clk_en    (pipe_clk_en),
      .debug_mode     (debug_mode),
      .debug_addr     (debug_addr),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .busy           (busy)
   );

   initial forever #5 clk = ~clk;

   // Pipeline-side state seen by the debug unit
   logic [31:0] regs_m [32];
   logic [31:0] mem_m  [256];
   logic [31:0] pc_m;

   assign pc_if = pc_m;
   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < 32; i++) regs_flat[i*32 +: 32] = regs_m[i];
   end

   initial begin
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_rdata = debug_mode ? mem_m[debug_addr[7:0]] : 32'hDEAD_BEEF;
      end
   end

   logic bp_on = 1'b0;
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = bp_on ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Monitor: byte capture, enable pulses, hold/freeze rules, instruction stream
   logic [7:0] rx_b [RXN];
   int  rx_n = 0;
   int  en_cycles = 0, pulses = 0, cur_w = 0, last_w = 0, dm_cycles = 0;
   int  hold_viol = 0, freeze_viol = 0;
   logic prev_en = 1'b0, prev_stall = 1'b0;
   logic [7:0] prev_dat = 8'h0;
   int  halt_at = 0, halt_base = 0;

   initial forever begin
      @(negedge clk);
      if (tx_valid && tx_ready && rx_n < RXN) begin
         rx_b[rx_n] = tx_data;
         rx_n++;
      end
      if (prev_stall && rst_n && (!tx_valid || tx_data != prev_dat)) hold_viol++;
      prev_stall = rst_n && tx_valid && !tx_ready;
      prev_dat   = tx_data;
      if (pipe_clk_en && (tx_valid || debug_mode)) freeze_viol++;
      if (debug_mode) dm_cycles++;
      if (pipe_clk_en) begin
         en_cycles++;
         if (!prev_en) begin
            pulses++;
            cur_w = 0;
         end
         cur_w++;
         last_w = cur_w;
      end
      prev_en = pipe_clk_en;
      if (pipe_clk_en && halt_at != 0 && (en_cycles - halt_base) == halt_at)
         instruction_if = HALT;
      else
         instruction_if = $urandom & 32'hFFFF_FFFE;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_data  = b;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
   endtask

   task automatic wait_idle(input string tag, input int max, output int cyc);
      cyc = 0;
      while (busy && cyc < max) begin
         tick();
         cyc++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic set_plan();
      pc_m = 32'h10;
      for (int i = 0; i < 32; i++) regs_m[i] = 32'(i);
      for (int k = 0; k < 256; k++) mem_m[k] = 32'h100 + 32'(k);
   endtask

   task automatic set_random();
      pc_m = $urandom;
      for (int i = 0; i < 32; i++) regs_m[i] = $urandom;
      for (int k = 0; k < 256; k++) mem_m[k] = $urandom;
   endtask

   logic [7:0] exp_b [2048];
   int exp_n;

   task automatic push_word(input logic [31:0] w);
      for (int s = 3; s >= 0; s--) begin
         exp_b[exp_n] = 8'((w >> (8 * s)) & 32'hFF);
         exp_n++;
      end
   endtask

   task automatic build_exp(input logic [31:0] cnt);
      exp_n = 0;
      exp_b[0] = 8'hA5;
      exp_n = 1;
      if (CW == 1) push_word(cnt);
      push_word(pc_m);
      for (int i = 0; i < 32; i++) push_word(regs_m[i]);
      for (int k = 0; k < MW; k++) push_word(mem_m[k]);
   endtask

   task automatic check_frame(input string tag, input int start);
      chk({tag, "_len"}, 32'(rx_n - start), 32'(exp_n));
      for (int i = 0; i < exp_n; i++)
         if (start + i < rx_n) chk($sformatf("%s_b%0d", tag, i), 32'(rx_b[start + i]), 32'(exp_b[i]));
   endtask

   initial begin
      int start, cyc, n, base_c, base_p, dm_base, hold_base;
      logic [31:0] model_cnt;

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_data = 8'h00;
      model_cnt = 32'd0;
      set_plan();
      repeat (3) tick();
      chk("rst_en", 32'(pipe_clk_en), 32'd0);
      chk("rst_dm", 32'(debug_mode), 32'd0);
      chk("rst_addr", debug_addr, 32'd0);
      chk("rst_txv", 32'(tx_valid), 32'd0);
      chk("rst_txd", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Plain dump with known values, latency and throughput
      start = rx_n;
      send_cmd(8'h64);
      chk("d_busy", 32'(busy), 32'd1);
      chk("d_txv_early", 32'(tx_valid), 32'd0);
      chk("d_en", 32'(pipe_clk_en), 32'd0);
      tick();
      chk("d_hdr_valid", 32'(tx_valid), 32'd1);
      chk("d_hdr_byte", 32'(tx_data), 32'hA5);
      dm_base = dm_cycles;
      wait_idle("d_idle", 3000, cyc);
      chk("d_cycles", 32'(cyc + 1), 32'(3 + 5 * (33 + CW) + 6 * MW));
      chk("d_dm_cycles", 32'(dm_cycles - dm_base), 32'(6 * MW));
      chk("d_dm_after", 32'(debug_mode), 32'd0);
      build_exp(model_cnt);
      check_frame("dump", start);

      // Three single steps
      for (int s = 0; s < 3; s++) begin
         base_c = en_cycles;
         base_p = pulses;
         start  = rx_n;
         send_cmd(8'h73);
         chk("s_en_on", 32'(pipe_clk_en), 32'd1);
         wait_idle("s_idle", 3000, cyc);
         chk("s_en_cycles", 32'(en_cycles - base_c), 32'd1);
         chk("s_pulses", 32'(pulses - base_p), 32'd1);
         chk("s_width", 32'(last_w), 32'd1);
         model_cnt = model_cnt + 32'd1;
         build_exp(model_cnt);
         check_frame($sformatf("step%0d", s), start);
      end

      // Run until HALT reaches IF on the 5th and on the 1st enabled cycle
      for (int h = 0; h < 2; h++) begin
         set_random();
         halt_at   = (h == 0) ? 5 : 1;
         halt_base = en_cycles;
         base_p    = pulses;
         start     = rx_n;
         send_cmd(8'h63);
         n = 0;
         while (pipe_clk_en && n < 50) begin
            tick();
            n++;
         end
         chk("c_stopped", 32'(pipe_clk_en), 32'd0);
         chk("c_hdr_early", 32'(tx_valid), 32'd0);
         tick();
         chk("c_hdr_valid", 32'(tx_valid), 32'd1);
         chk("c_hdr_byte", 32'(tx_data), 32'hA5);
         wait_idle("c_idle", 3000, cyc);
         chk("c_en_cycles", 32'(en_cycles - halt_base), 32'(halt_at));
         chk("c_pulses", 32'(pulses - base_p), 32'd1);
         model_cnt = model_cnt + 32'(halt_at);
         build_exp(model_cnt);
         check_frame($sformatf("halt%0d", halt_at), start);
         halt_at = 0;
      end

      // Run stopped by 'h' on cycle 10; a 'd' during SEND must be dropped
      set_random();
      base_c = en_cycles;
      start  = rx_n;
      send_cmd(8'h63);
      repeat (9) tick();
      send_cmd(8'h68);
      chk("h_stopped", 32'(pipe_clk_en), 32'd0);
      tick();
      chk("h_sending", 32'(tx_valid), 32'd1);
      send_cmd(8'h64);
      wait_idle("h_idle", 3000, cyc);
      chk("h_en_cycles", 32'(en_cycles - base_c), 32'd10);
      model_cnt = model_cnt + 32'd10;
      build_exp(model_cnt);
      check_frame("hcmd", start);
      repeat (20) tick();
      chk("h_one_frame", 32'(rx_n - start), 32'(exp_n));
      chk("h_busy_after", 32'(busy), 32'd0);

      // Backpressure: known values, then random values
      for (int b = 0; b < 2; b++) begin
         if (b == 0) set_plan();
         else set_random();
         bp_on     = 1'b1;
         hold_base = hold_viol;
         start     = rx_n;
         send_cmd(8'h64);
         wait_idle("bp_idle", 12000, cyc);
         bp_on = 1'b0;
         chk("bp_hold", 32'(hold_viol - hold_base), 32'd0);
         build_exp(model_cnt);
         check_frame($sformatf("bp%0d", b), start);
      end

      // Reset in the middle of a frame
      set_random();
      start = rx_n;
      send_cmd(8'h64);
      n = 0;
      while (rx_n - start < 50 && n < 3000) begin
         tick();
         n++;
      end
      chk("r_reached50", 32'(rx_n - start >= 50), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("r_en", 32'(pipe_clk_en), 32'd0);
      chk("r_dm", 32'(debug_mode), 32'd0);
      chk("r_addr", debug_addr, 32'd0);
      chk("r_txv", 32'(tx_valid), 32'd0);
      chk("r_txd", 32'(tx_data), 32'd0);
      chk("r_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_cnt = 32'd0;
      tick();
      start = rx_n;
      send_cmd(8'h64);
      wait_idle("r_idle", 3000, cyc);
      build_exp(model_cnt);
      check_frame("after_rst", start);

      chk("freeze", 32'(freeze_viol), 32'd0);
      chk("hold_total", 32'(hold_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
